// File: rtl/result_fifo_if.sv
// Valid/ready handshake bundle between the adder register, result_fifo and its consumer.
interface result_fifo_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/result_fifo.sv
// In-order result buffer after the adder register; full writes are dropped and flagged.
// Optional drop counter enabled by defining RESULT_FIFO_OVF_CNT_EN.
module result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    result_fifo_if.slave               bus,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
`ifdef RESULT_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]                 o_ovf_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_push  = bus.in_valid && (!w_full || w_pop);
    assign w_drop  = bus.in_valid && w_full && !w_pop;

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;

    // Storage is only written by an accepted push; clear leaves contents stale but unreachable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!i_clear && w_push) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef RESULT_FIFO_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    // Saturates so a long overflow burst never reads back as a small count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_cnt <= 8'd0;
        end else if (i_clear) begin
            r_ovf_cnt <= 8'd0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign o_ovf_count = r_ovf_cnt;
`endif

endmodule
